// File: rtl/cpu_boot_loader.sv
// Boot loader: accepts a framed program (length, payload, checksum), writes it into
// instruction memory, reads it back to verify the checksum, then enables the CPU.
module cpu_boot_loader #(
    parameter int IMEM_WORDS = 512,
    parameter int ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);
    // Wide enough to hold IMEM_WORDS itself, so a full-depth image needs no wrap.
    localparam int IDX_W = $clog2(IMEM_WORDS + 1);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, TRAIL, VERIFY, CMP, RUN, ERR} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] len, len_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [31:0]      ssum, ssum_n;
    logic [31:0]      rsum, rsum_n;
    logic [31:0]      csum, csum_n;
    logic [31:0]      rsum_acc;
    logic             wr_pend, wr_pend_n;
    logic             rd_pend;
    logic [63:0]      addr_n;
    logic             wen_n, ren_n;
    logic [31:0]      wdata_n;
    logic [1:0]       err_code_n;
    logic             beat;

    // The only combinational output: blocks the beat following a payload word.
    assign s_ready = (state == HDR) || (state == TRAIL) || (state == LOAD && !wr_pend);
    assign beat    = s_valid && s_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_n    = state;
        len_n      = len;
        idx_n      = idx;
        ssum_n     = ssum;
        rsum_n     = rsum;
        csum_n     = csum;
        wr_pend_n  = 1'b0;
        wen_n      = 1'b0;
        ren_n      = 1'b0;
        addr_n     = '0;
        wdata_n    = '0;
        err_code_n = err_code;
        rsum_acc   = rsum + (rd_pend ? rdata_ext : 32'd0);

        case (state)
            IDLE, ERR: begin
                if (start) begin
                    state_n    = HDR;
                    err_code_n = 2'd0;
                end
            end
            HDR: begin
                if (beat) begin
                    if (s_data == 32'd0 || s_data > 32'(IMEM_WORDS)) begin
                        state_n    = ERR;
                        err_code_n = 2'd1;
                    end else begin
                        len_n   = s_data[IDX_W-1:0];
                        idx_n   = '0;
                        ssum_n  = '0;
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                if (wr_pend) begin
                    idx_n = idx + IDX_W'(1);
                    if (idx == len - IDX_W'(1)) state_n = TRAIL;
                end else if (beat) begin
                    ssum_n    = ssum + s_data;
                    wr_pend_n = 1'b1;
                    wen_n     = 1'b1;
                    addr_n    = 64'(idx) * 64'(ADDR_STEP);
                    wdata_n   = s_data;
                end
            end
            TRAIL: begin
                if (beat) begin
                    if (s_data != ssum) begin
                        state_n    = ERR;
                        err_code_n = 2'd2;
                    end else begin
                        csum_n  = s_data;
                        rsum_n  = '0;
                        ren_n   = 1'b1;
                        idx_n   = IDX_W'(1);
                        state_n = VERIFY;
                    end
                end
            end
            VERIFY: begin
                // idx counts reads already issued, including the one on the port now.
                rsum_n = rsum_acc;
                if (idx == len) begin
                    state_n = CMP;
                end else begin
                    ren_n  = 1'b1;
                    addr_n = 64'(idx) * 64'(ADDR_STEP);
                    idx_n  = idx + IDX_W'(1);
                end
            end
            CMP: begin
                rsum_n = rsum_acc;
                if (rsum_acc == csum) begin
                    state_n = RUN;
                end else begin
                    state_n    = ERR;
                    err_code_n = 2'd3;
                end
            end
            RUN:     state_n = RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            ssum       <= '0;
            rsum       <= '0;
            csum       <= '0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            addr_ext   <= '0;
            wen_ext    <= 1'b0;
            ren_ext    <= 1'b0;
            wdata_ext  <= '0;
            err_code   <= '0;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from the values of the previous cycle.
            state      <= state_n;
            len        <= len_n;
            idx        <= idx_n;
            ssum       <= ssum_n;
            rsum       <= rsum_n;
            csum       <= csum_n;
            wr_pend    <= wr_pend_n;
            rd_pend    <= ren_ext;
            addr_ext   <= addr_n;
            wen_ext    <= wen_n;
            ren_ext    <= ren_n;
            wdata_ext  <= wdata_n;
            err_code   <= err_code_n;
            cpu_enable <= (state_n == RUN);
            done       <= (state_n == RUN);
            error      <= (state_n == ERR);
            busy       <= state_n inside {HDR, LOAD, TRAIL, VERIFY, CMP};
        end
    end
endmodule
